// File: rtl/m_muldiv_seq_if.sv
// m_muldiv_seq_if: control-side handshake between the decoder and the mul/div sequencer
interface m_muldiv_seq_if;
  logic start;
  logic stall;
  logic [2:0] func3;
  logic busy;
  logic done;
  modport master(output start, stall, func3, input busy, done);
  modport slave(input start, stall, func3, output busy, done);
endinterface

// File: rtl/m_muldiv_seq.sv
// m_muldiv_seq: add/shift iteration sequencer driving the mul/div datapath
module m_muldiv_seq #(
  parameter int NITER = 32
) (
  input  logic             clk,
  input  logic             rst,
  m_muldiv_seq_if.slave    bus,
  input  logic             rs1_31,
  input  logic             rs2_31,
  input  logic             rs2_zero,
  input  logic             alu_carryout,
  output logic             use_dinx,
  output logic             ceM,
  output logic             cond_holdq,
  output logic             negate,
  output logic             divz
);
  localparam int CW = $clog2(NITER);
  typedef enum logic [2:0] {IDLE, PREP, ADD, SHIFT, FIX, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] f3;
  logic neg, last, step;
  assign last = cnt == CW'(NITER - 1);
  assign step = f3[2] ? state == ADD : state == SHIFT;
  // state register, frozen by stall
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else if (!bus.stall) state <= nxt;
  // operation context: latched func3, sign fix-up, div-by-zero, iteration count
  always_ff @(posedge clk)
    if (rst) begin
      cnt  <= '0;
      f3   <= '0;
      neg  <= 1'b0;
      divz <= 1'b0;
    end else if (!bus.stall) begin
      if (state == IDLE && bus.start) begin
        f3   <= bus.func3;
        divz <= 1'b0;
      end
      if (state == PREP) begin
        divz <= rs2_zero & f3[2];
        neg  <= f3 == 3'b100 ? (rs1_31 ^ rs2_31) & ~rs2_zero :
                f3 == 3'b110 ? rs1_31 & ~rs2_zero : 1'b0;
      end
      if (step) cnt <= cnt + CW'(1);
    end
  // next state: MUL class pairs ADD->SHIFT, DIV class pairs SHIFT->ADD
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? PREP : IDLE;
      PREP:    nxt = f3[2] ? SHIFT : ADD;
      ADD:     nxt = step && last ? (neg ? FIX : DONE) : SHIFT;
      SHIFT:   nxt = step && last ? (neg ? FIX : DONE) : ADD;
      FIX:     nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // outputs decoded from state; cond_holdq also follows the live carry
  always_comb begin
    bus.busy   = state != IDLE;
    bus.done   = state == DONE;
    use_dinx   = state == PREP;
    ceM        = state == SHIFT;
    negate     = state == FIX;
    cond_holdq = state == ADD && f3[2] && !alu_carryout;
  end
endmodule
